// File: rtl/unlock_sequencer.sv
// Keypad door lock controller: password check, alarm on wrong entry, timed lockout
// after repeated failures, and an in-place password change mode.
module unlock_sequencer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int MAX_TRIES = 3,
  parameter int LOCK_SEC  = 30,
  parameter int ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       open_close,
  input  logic       reset_pw,
  input  logic       confirm_pw,
  input  logic       clean_pw,
  input  logic [3:0] p0,
  input  logic [3:0] p1,
  input  logic [3:0] p2,
  input  logic [3:0] p3,
  output logic       opened,
  output logic       show_pw,
  output logic       clear_entry,
  output logic       alarm,
  output logic       locked_out,
  output logic [1:0] fail_cnt,
  output logic [5:0] countdown
);

  localparam logic [1:0] S_LOCKED  = 2'd0;
  localparam logic [1:0] S_OPEN    = 2'd1;
  localparam logic [1:0] S_SETPW   = 2'd2;
  localparam logic [1:0] S_LOCKOUT = 2'd3;

  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(CLK_HZ - 1);
  localparam logic [5:0]         LOCK_INIT  = 6'(LOCK_SEC);
  localparam logic [5:0]         ALARM_INIT = 6'(ALARM_SEC);
  localparam logic [2:0]         TRY_LIMIT  = 3'(MAX_TRIES);

  logic [1:0]         state_q, state_d;
  logic [15:0]        pw_q, pw_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [5:0]         alarmTmr_q, alarmTmr_d;
  logic [5:0]         countdown_q, countdown_d;
  logic [1:0]         fail_q, fail_d;
  logic               opened_q, opened_d;
  logic               show_q, show_d;
  logic               clear_q, clear_d;
  logic               alarm_q, alarm_d;
  logic               lockout_q, lockout_d;

  logic        tick;
  logic [15:0] entry;
  logic        pwMatch;
  logic [2:0]  failNext;
  logic        keyOpen, keyConfirm, keyClean, keyReset;
  logic        wantClear;

  assign entry    = {p3, p2, p1, p0};
  assign tick     = (presc_q == PRESC_MAX);
  assign pwMatch  = (entry == pw_q);
  assign failNext = {1'b0, fail_q} + 3'd1;

  // Only the highest-priority pulse of a cycle is acted on; the rest are dropped.
  assign keyOpen    = open_close;
  assign keyConfirm = confirm_pw & ~open_close;
  assign keyClean   = clean_pw & ~open_close & ~confirm_pw;
  assign keyReset   = reset_pw & ~open_close & ~confirm_pw & ~clean_pw;

  always_comb begin
    state_d     = state_q;
    pw_d        = pw_q;
    presc_d     = tick ? '0 : presc_q + 1'b1;
    alarmTmr_d  = alarmTmr_q;
    countdown_d = countdown_q;
    fail_d      = fail_q;
    opened_d    = opened_q;
    show_d      = show_q;
    alarm_d     = alarm_q;
    lockout_d   = lockout_q;
    wantClear   = 1'b0;

    case (state_q)
      S_LOCKED: begin
        if (tick && alarmTmr_q != 6'd0) begin
          alarmTmr_d = alarmTmr_q - 6'd1;
          if (alarmTmr_q == 6'd1) alarm_d = 1'b0;
        end
        if (keyOpen) begin
          wantClear = 1'b1;
          if (pwMatch) begin
            state_d    = S_OPEN;
            opened_d   = 1'b1;
            fail_d     = 2'd0;
            alarm_d    = 1'b0;
            alarmTmr_d = 6'd0;
          end else if (failNext < TRY_LIMIT) begin
            fail_d     = failNext[1:0];
            alarm_d    = 1'b1;
            alarmTmr_d = ALARM_INIT;
            presc_d    = '0;
          end else begin
            state_d     = S_LOCKOUT;
            lockout_d   = 1'b1;
            alarm_d     = 1'b1;
            countdown_d = LOCK_INIT;
            fail_d      = 2'd0;
            alarmTmr_d  = 6'd0;
            presc_d     = '0;
          end
        end
      end
      S_OPEN: begin
        if (keyOpen) begin
          state_d   = S_LOCKED;
          opened_d  = 1'b0;
          wantClear = 1'b1;
        end else if (keyClean) begin
          pw_d = 16'h0000;
        end else if (keyReset) begin
          state_d   = S_SETPW;
          show_d    = 1'b1;
          wantClear = 1'b1;
        end
      end
      S_SETPW: begin
        if (keyOpen) begin
          state_d   = S_LOCKED;
          show_d    = 1'b0;
          opened_d  = 1'b0;
          wantClear = 1'b1;
        end else if (keyConfirm) begin
          pw_d      = entry;
          state_d   = S_OPEN;
          show_d    = 1'b0;
          wantClear = 1'b1;
        end else if (keyClean) begin
          pw_d    = 16'h0000;
          state_d = S_OPEN;
          show_d  = 1'b0;
        end
      end
      default: begin
        if (tick) begin
          countdown_d = countdown_q - 6'd1;
          if (countdown_q == 6'd1) begin
            state_d   = S_LOCKED;
            lockout_d = 1'b0;
            alarm_d   = 1'b0;
          end
        end
      end
    endcase

    // A clear request right after a clear pulse is swallowed so the pulse stays one cycle.
    clear_d = wantClear & ~clear_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOCKED;
      pw_q        <= 16'h0000;
      presc_q     <= '0;
      alarmTmr_q  <= 6'd0;
      countdown_q <= 6'd0;
      fail_q      <= 2'd0;
      opened_q    <= 1'b0;
      show_q      <= 1'b0;
      clear_q     <= 1'b0;
      alarm_q     <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pw_q        <= pw_d;
      presc_q     <= presc_d;
      alarmTmr_q  <= alarmTmr_d;
      countdown_q <= countdown_d;
      fail_q      <= fail_d;
      opened_q    <= opened_d;
      show_q      <= show_d;
      clear_q     <= clear_d;
      alarm_q     <= alarm_d;
      lockout_q   <= lockout_d;
    end
  end

  assign opened      = opened_q;
  assign show_pw     = show_q;
  assign clear_entry = clear_q;
  assign alarm       = alarm_q;
  assign locked_out  = lockout_q;
  assign fail_cnt    = fail_q;
  assign countdown   = countdown_q;

endmodule

// File: tb/tb_unlock_sequencer.sv
// Self-checking bench for unlock_sequencer: directed scenarios with literal expectations,
// then random key traffic compared every cycle against a behavioural model.
module tb_unlock_sequencer;

  localparam int CLK_HZ    = 10;
  localparam int MAX_TRIES = 3;
  localparam int LOCK_SEC  = 3;
  localparam int ALARM_SEC = 2;

  logic       clk;
  logic       rst;
  logic       open_close, reset_pw, confirm_pw, clean_pw;
  logic [3:0] p0, p1, p2, p3;
  logic       opened, show_pw, clear_entry, alarm, locked_out;
  logic [1:0] fail_cnt;
  logic [5:0] countdown;

  int nVec;
  int nMiss;
  bit checkEn;

  typedef enum int {M_LOCKED, M_OPEN, M_SETPW, M_LOCKOUT} mode_t;
  mode_t       mMode;
  logic [15:0] mPw;
  bit          mOpened, mShow, mClear, mAlarm, mLocked;
  int          mFail, mCountdown, mAlarmLeft, mPhase;

  unlock_sequencer #(
    .CLK_HZ(CLK_HZ), .MAX_TRIES(MAX_TRIES), .LOCK_SEC(LOCK_SEC), .ALARM_SEC(ALARM_SEC)
  ) dut (
    .clk(clk), .rst(rst),
    .open_close(open_close), .reset_pw(reset_pw), .confirm_pw(confirm_pw), .clean_pw(clean_pw),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3),
    .opened(opened), .show_pw(show_pw), .clear_entry(clear_entry), .alarm(alarm),
    .locked_out(locked_out), .fail_cnt(fail_cnt), .countdown(countdown)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mMode = M_LOCKED; mPw = 16'h0000;
    mOpened = 0; mShow = 0; mClear = 0; mAlarm = 0; mLocked = 0;
    mFail = 0; mCountdown = 0; mAlarmLeft = 0; mPhase = 0;
  endtask

  // One clock of the door's behaviour: seconds tick, then the winning key pulse.
  task automatic modelStep(input bit oc, input bit rp, input bit cf, input bit cl,
                           input logic [15:0] e);
    bit tick;
    bit wantClear;
    int key;
    tick = (mPhase == CLK_HZ - 1);
    mPhase = tick ? 0 : mPhase + 1;
    wantClear = 0;
    key = oc ? 1 : cf ? 2 : cl ? 3 : rp ? 4 : 0;
    case (mMode)
      M_LOCKED: begin
        if (tick && mAlarmLeft > 0) begin
          mAlarmLeft--;
          if (mAlarmLeft == 0) mAlarm = 0;
        end
        if (key == 1) begin
          wantClear = 1;
          if (e == mPw) begin
            mMode = M_OPEN; mOpened = 1; mFail = 0; mAlarm = 0; mAlarmLeft = 0;
          end else if (mFail + 1 < MAX_TRIES) begin
            mFail++; mAlarm = 1; mAlarmLeft = ALARM_SEC; mPhase = 0;
          end else begin
            mMode = M_LOCKOUT; mLocked = 1; mAlarm = 1; mCountdown = LOCK_SEC;
            mFail = 0; mAlarmLeft = 0; mPhase = 0;
          end
        end
      end
      M_OPEN: begin
        if (key == 1) begin
          mMode = M_LOCKED; mOpened = 0; wantClear = 1;
        end else if (key == 3) begin
          mPw = 16'h0000;
        end else if (key == 4) begin
          mMode = M_SETPW; mShow = 1; wantClear = 1;
        end
      end
      M_SETPW: begin
        if (key == 1) begin
          mMode = M_LOCKED; mShow = 0; mOpened = 0; wantClear = 1;
        end else if (key == 2) begin
          mPw = e; mMode = M_OPEN; mShow = 0; wantClear = 1;
        end else if (key == 3) begin
          mPw = 16'h0000; mMode = M_OPEN; mShow = 0;
        end
      end
      default: begin
        if (tick) begin
          mCountdown--;
          if (mCountdown == 0) begin
            mMode = M_LOCKED; mLocked = 0; mAlarm = 0;
          end
        end
      end
    endcase
    mClear = wantClear && !mClear;
  endtask

  task automatic applyStimulus(input bit oc, input bit rp, input bit cf, input bit cl,
                               input logic [15:0] e);
    open_close = oc; reset_pw = rp; confirm_pw = cf; clean_pw = cl;
    {p3, p2, p1, p0} = e;
    @(posedge clk);
    modelStep(oc, rp, cf, cl, e);
    #1;
    open_close = 0; reset_pw = 0; confirm_pw = 0; clean_pw = 0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 16'h0000);
  endtask

  task automatic doReset();
    #2 rst = 0;
    modelReset();
    @(negedge clk);
    rst = 1;
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("opened",      16'(opened),      16'(mOpened));
      checkOutput("show_pw",     16'(show_pw),     16'(mShow));
      checkOutput("clear_entry", 16'(clear_entry), 16'(mClear));
      checkOutput("alarm",       16'(alarm),       16'(mAlarm));
      checkOutput("locked_out",  16'(locked_out),  16'(mLocked));
      checkOutput("fail_cnt",    16'(fail_cnt),    16'(mFail));
      checkOutput("countdown",   16'(countdown),   16'(mCountdown));
    end
  end

  initial begin
    int aCount;
    int r;
    logic [15:0] e;
    nVec = 0; nMiss = 0; checkEn = 0;
    rst = 1;
    open_close = 0; reset_pw = 0; confirm_pw = 0; clean_pw = 0;
    {p3, p2, p1, p0} = 16'h0000;
    modelReset();
    #1 rst = 0;
    @(negedge clk);
    checkEn = 1;
    @(negedge clk);
    checkOutput("rst_opened", 16'(opened), 16'd0);
    checkOutput("rst_countdown", 16'(countdown), 16'd0);
    rst = 1;

    applyStimulus(1, 0, 0, 0, 16'h0000);
    checkOutput("first_open", 16'(opened), 16'd1);
    checkOutput("first_open_fail", 16'(fail_cnt), 16'd0);
    checkOutput("first_open_clear", 16'(clear_entry), 16'd1);
    idle(1);
    checkOutput("clear_one_cycle", 16'(clear_entry), 16'd0);

    applyStimulus(0, 1, 0, 0, 16'h0000);
    checkOutput("setpw_show", 16'(show_pw), 16'd1);
    idle(1);
    applyStimulus(0, 0, 1, 0, 16'h1234);
    checkOutput("confirm_show", 16'(show_pw), 16'd0);
    checkOutput("confirm_opened", 16'(opened), 16'd1);
    idle(1);
    applyStimulus(1, 0, 0, 0, 16'h1234);
    checkOutput("close_opened", 16'(opened), 16'd0);
    idle(1);
    applyStimulus(1, 0, 0, 0, 16'h1234);
    checkOutput("newpw_opens", 16'(opened), 16'd1);
    idle(1);
    applyStimulus(1, 0, 0, 0, 16'h1234);
    idle(1);
    applyStimulus(1, 0, 0, 0, 16'h0000);
    checkOutput("wrong_alarm", 16'(alarm), 16'd1);
    checkOutput("wrong_fail", 16'(fail_cnt), 16'd1);

    aCount = 1;
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (alarm) aCount++;
      else break;
    end
    checkOutput("alarm_width", 16'(aCount), 16'd20);
    checkOutput("alarm_fail_kept", 16'(fail_cnt), 16'd1);

    applyStimulus(1, 0, 0, 0, 16'h0000);
    checkOutput("second_wrong_fail", 16'(fail_cnt), 16'd2);
    idle(1);
    applyStimulus(1, 0, 0, 0, 16'h0000);
    checkOutput("lockout_flag", 16'(locked_out), 16'd1);
    checkOutput("lockout_count", 16'(countdown), 16'd3);
    checkOutput("lockout_fail", 16'(fail_cnt), 16'd0);
    checkOutput("model_countdown", 16'(mCountdown), 16'd3);
    for (int k = 1; k <= 30; k++) begin
      if (k == 15) applyStimulus(1, 0, 0, 0, 16'h1234);
      else idle(1);
      if (k == 9)  checkOutput("cd_k9", 16'(countdown), 16'd3);
      if (k == 10) checkOutput("cd_k10", 16'(countdown), 16'd2);
      if (k == 15) checkOutput("lockout_ignores", 16'(opened), 16'd0);
      if (k == 29) checkOutput("cd_k29", 16'(countdown), 16'd1);
      if (k == 30) begin
        checkOutput("lockout_end_flag", 16'(locked_out), 16'd0);
        checkOutput("lockout_end_alarm", 16'(alarm), 16'd0);
        checkOutput("lockout_end_cd", 16'(countdown), 16'd0);
      end
    end

    applyStimulus(1, 0, 0, 0, 16'h1234);
    idle(1);
    applyStimulus(0, 1, 0, 0, 16'h1234);
    idle(1);
    applyStimulus(1, 0, 1, 0, 16'h5555);
    checkOutput("oc_beats_confirm", 16'(opened), 16'd0);
    checkOutput("oc_beats_confirm_show", 16'(show_pw), 16'd0);
    idle(1);
    applyStimulus(1, 0, 0, 0, 16'h5555);
    checkOutput("pw_unchanged_alarm", 16'(alarm), 16'd1);
    idle(1);
    applyStimulus(1, 0, 0, 0, 16'h1234);
    checkOutput("pw_unchanged_open", 16'(opened), 16'd1);
    idle(1);

    applyStimulus(0, 0, 0, 1, 16'h9999);
    idle(1);
    applyStimulus(1, 0, 0, 0, 16'h9999);
    idle(1);
    applyStimulus(1, 0, 0, 0, 16'h0000);
    checkOutput("clean_opens_0000", 16'(opened), 16'd1);
    checkOutput("model_pw_clean", mPw, 16'h0000);
    idle(1);

    applyStimulus(1, 0, 0, 0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      applyStimulus(1, 0, 0, 0, 16'h1111);
    end
    checkOutput("lockout_again", 16'(locked_out), 16'd1);
    idle(5);
    doReset();
    checkOutput("rst_lockout_flag", 16'(locked_out), 16'd0);
    checkOutput("rst_lockout_alarm", 16'(alarm), 16'd0);
    applyStimulus(1, 0, 0, 0, 16'h0000);
    checkOutput("rst_then_open", 16'(opened), 16'd1);
    idle(1);
    applyStimulus(0, 1, 0, 0, 16'h7777);
    idle(2);
    doReset();
    checkOutput("rst_setpw_show", 16'(show_pw), 16'd0);
    applyStimulus(1, 0, 0, 0, 16'h0000);
    checkOutput("rst_setpw_open", 16'(opened), 16'd1);

    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 99));
      case ($urandom_range(0, 2))
        0: e = mPw;
        1: e = 16'h1234;
        default: e = 16'($urandom);
      endcase
      if ($urandom_range(0, 599) == 0) doReset();
      else if (r < 5)  applyStimulus(1, 0, 0, 0, e);
      else if (r < 9)  applyStimulus(0, 1, 0, 0, e);
      else if (r < 13) applyStimulus(0, 0, 1, 0, e);
      else if (r < 16) applyStimulus(0, 0, 0, 1, e);
      else if (r < 19) applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), e);
      else applyStimulus(0, 0, 0, 0, e);
    end

    idle(2);
    checkEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

// File: doc/unlock_sequencer.md
UNLOCK_SEQUENCER -- requirements
Module: unlock_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, clock cycles per 1 s tick.
REQ-002 SHALL have parameter MAX_TRIES, default 3, number of consecutive wrong attempts that triggers lockout (legal 1..3).
REQ-003 SHALL have parameter LOCK_SEC, default 30, lockout duration in seconds (legal 1..63).
REQ-004 SHALL have parameter ALARM_SEC, default 10, alarm duration after a single wrong attempt (legal 1..63).
REQ-005 SHALL have ports: clk  in  1  system clock, single clock domain.
REQ-006 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: open_close, reset_pw, confirm_pw, clean_pw  in  1 each  debounced one-cycle key pulses.
REQ-008 SHALL have ports: p0, p1, p2, p3  in  4 each  currently entered digits.
REQ-009 SHALL have ports: opened  out  1  door unlocked.
REQ-010 SHALL have ports: show_pw  out  1  display digits instead of '-'.
REQ-011 SHALL have ports: clear_entry  out  1  one-cycle pulse that clears the keypad entry.
REQ-012 SHALL have ports: alarm  out  1  alarm LED/buzzer enable.
REQ-013 SHALL have ports: locked_out  out  1  lockout active.
REQ-014 SHALL have ports: fail_cnt  out  2  consecutive wrong attempts.
REQ-015 SHALL have ports: countdown  out  6  lockout seconds remaining, 0 when not locked out.

Function
REQ-016 SHALL implement FSM states LOCKED, OPEN, SETPW, LOCKOUT; all outputs registered; every response appears on the cycle after the triggering pulse.
REQ-017 SHALL hold a 16-bit stored password cp3..cp0, reset value 0000.
REQ-018 SHALL derive a 1 s tick from a prescaler counting 0..CLK_HZ-1; prescaler cleared on entry to LOCKOUT and on each alarm (re)start.
REQ-019 LOCKED + open_close, {p3..p0}=={cp3..cp0}: go to OPEN, opened=1, fail_cnt=0, alarm=0, clear_entry pulse.
REQ-020 LOCKED + open_close, mismatch, fail_cnt+1<MAX_TRIES: stay LOCKED, fail_cnt+1, alarm=1, alarm timer=ALARM_SEC, clear_entry pulse.
REQ-021 LOCKED + open_close, mismatch, fail_cnt+1==MAX_TRIES: go to LOCKOUT, locked_out=1, alarm=1, countdown=LOCK_SEC, fail_cnt=0, clear_entry pulse.
REQ-022 In LOCKED, alarm timer decrements per tick; alarm deasserts the cycle after timer reaches 0; a new wrong attempt restarts the timer at ALARM_SEC.
REQ-023 In LOCKOUT, all key pulses ignored; countdown decrements per tick; on reaching 0, go to LOCKED, locked_out=0, alarm=0.
REQ-024 OPEN + open_close: go to LOCKED, opened=0, clear_entry pulse.
REQ-025 OPEN + reset_pw: go to SETPW, show_pw=1, clear_entry pulse.
REQ-026 OPEN + clean_pw: stored password=0000, stay OPEN.
REQ-027 SETPW + confirm_pw: cp3..cp0<=p3..p0, go to OPEN, show_pw=0, clear_entry pulse.
REQ-028 SETPW + open_close: go to LOCKED, password unchanged, show_pw=0, opened=0, clear_entry pulse.
REQ-029 SETPW + clean_pw: stored password=0000, go to OPEN, show_pw=0.
REQ-030 Simultaneous pulses: priority open_close > confirm_pw > clean_pw > reset_pw; lower-priority pulses in the same cycle discarded.
REQ-031 confirm_pw in LOCKED or OPEN, and reset_pw in LOCKED or SETPW, SHALL have no effect.
REQ-032 clear_entry SHALL be exactly one cycle wide, never asserted two consecutive cycles.

Reset
REQ-033 rst low SHALL immediately force LOCKED, stored password 0000, opened=0, show_pw=0, clear_entry=0, alarm=0, locked_out=0, fail_cnt=0, countdown=0, prescaler and timers 0.
REQ-034 Reset asserted mid-LOCKOUT or mid-SETPW SHALL abort that operation with no partial password write.

Verification (CLK_HZ=10, MAX_TRIES=3, LOCK_SEC=3, ALARM_SEC=2)
REQ-035 After reset, p=0000, open_close -> next cycle opened=1, fail_cnt=0, clear_entry=1 for 1 cycle.
REQ-036 OPEN, reset_pw, p=1234, confirm_pw, open_close; then p=1234 + open_close -> opened=1; p=0000 + open_close -> alarm=1, fail_cnt=1.
REQ-037 One wrong attempt -> alarm=1 for 20 cycles (2 ticks), then alarm=0, fail_cnt stays 1.
REQ-038 Three wrong attempts -> locked_out=1, countdown=3; decrements every 10 cycles; correct code during lockout ignored; after 30 cycles LOCKED, alarm=0.
REQ-039 SETPW with open_close and confirm_pw same cycle -> LOCKED, password unchanged.
REQ-040 rst pulsed low during LOCKOUT -> all outputs reset values, p=0000 + open_close opens.
